// File: rtl/wb_stage_if.sv
// +--------------------------------------------------------------------------+
// | Module      : wb_stage_if                                                |
// | Description : MEM/WB input bundle, ID-stage lookup and register-file     |
// |               write port of the write-back stage.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic             mw_valid;
    logic             mw_reg_write;
    logic [1:0]       mw_ld_type;
    logic [1:0]       mw_addr_lo;
    logic [RADDR-1:0] mw_rd;
    logic [XLEN-1:0]  mw_ex_result;
    logic [XLEN-1:0]  mw_mem_data;
    logic [RADDR-1:0] id_rs;
    logic [RADDR-1:0] id_rt;

    logic [RADDR-1:0] rd_addr;
    logic [3:0]       rd_byte_w_en;
    logic [XLEN-1:0]  rd_data;
    logic [3:0]       rs_out_sel;
    logic [3:0]       rt_out_sel;
    logic [XLEN-1:0]  retired;

    modport master (
        output mw_valid, mw_reg_write, mw_ld_type, mw_addr_lo, mw_rd,
               mw_ex_result, mw_mem_data, id_rs, id_rt,
        input  rd_addr, rd_byte_w_en, rd_data, rs_out_sel, rt_out_sel, retired
    );

    modport slave (
        input  mw_valid, mw_reg_write, mw_ld_type, mw_addr_lo, mw_rd,
               mw_ex_result, mw_mem_data, id_rs, id_rt,
        output rd_addr, rd_byte_w_en, rd_data, rs_out_sel, rt_out_sel, retired
    );
endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
// +--------------------------------------------------------------------------+
// | Module      : wb_stage                                                   |
// | Description : Write-back stage: MEM/WB register, lw/lwl(/lwr) alignment,|
// |               byte write enables and per-byte ID forwarding selects.     |
// |               Define WB_LWR_EN to enable ld_type 11 as big-endian lwr.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   stall,
    input  wire logic   flush,
    wb_stage_if.slave   wb
);

    localparam logic [1:0] c_LD_ALU = 2'b00;
    localparam logic [1:0] c_LD_LW  = 2'b01;
    localparam logic [1:0] c_LD_LWL = 2'b10;

    logic             r_valid;
    logic             r_reg_write;
    logic [1:0]       r_ld_type;
    logic [1:0]       r_addr_lo;
    logic [RADDR-1:0] r_rd;
    logic [XLEN-1:0]  r_ex_result;
    logic [XLEN-1:0]  r_mem_data;
    logic [XLEN-1:0]  r_retired;

    logic [3:0]       w_lane_en;
    logic [XLEN-1:0]  w_data;
    logic             w_write;
    logic [3:0]       w_en;

    // Flush only kills valid; the remaining fields are don't-care and simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_ld_type   <= 2'b00;
            r_addr_lo   <= 2'b00;
            r_rd        <= '0;
            r_ex_result <= '0;
            r_mem_data  <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (!stall) begin
            r_valid     <= wb.mw_valid;
            r_reg_write <= wb.mw_reg_write;
            r_ld_type   <= wb.mw_ld_type;
            r_addr_lo   <= wb.mw_addr_lo;
            r_rd        <= wb.mw_rd;
            r_ex_result <= wb.mw_ex_result;
            r_mem_data  <= wb.mw_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (!flush && !stall && wb.mw_valid) begin
            r_retired <= r_retired + XLEN'(1);
        end
    end

    // Memory word is big-endian: lwl moves the addressed byte to the MSB lane,
    // lwr moves it to the LSB lane (shift by 3-o, i.e. ~o for two bits).
    always_comb begin
        w_data    = '0;
        w_lane_en = 4'b0000;
        case (r_ld_type)
            c_LD_ALU: begin
                w_data    = r_ex_result;
                w_lane_en = 4'b1111;
            end
            c_LD_LW: begin
                w_data    = r_mem_data;
                w_lane_en = 4'b1111;
            end
            c_LD_LWL: begin
                w_data    = r_mem_data << {r_addr_lo, 3'b000};
                w_lane_en = 4'b1111 << r_addr_lo;
            end
            default: begin
`ifdef WB_LWR_EN
                w_data    = r_mem_data >> {~r_addr_lo, 3'b000};
                w_lane_en = 4'b1111 >> ~r_addr_lo;
`else
                w_data    = '0;
                w_lane_en = 4'b0000;
`endif
            end
        endcase
    end

    assign w_write = r_valid && r_reg_write && (r_rd != '0);
    assign w_en    = w_write ? w_lane_en : 4'b0000;

    assign wb.rd_addr      = r_rd;
    assign wb.rd_byte_w_en = w_en;
    assign wb.rd_data      = w_data;
    assign wb.rs_out_sel   = (r_rd == wb.id_rs) ? w_en : 4'b0000;
    assign wb.rt_out_sel   = (r_rd == wb.id_rt) ? w_en : 4'b0000;
    assign wb.retired      = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_stage                                                |
// | Description : Self-checking bench for wb_stage: vector table, corner     |
// |               sequences and randomized run against a byte-level model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_stage;

    logic clk = 1'b0;
    logic rst, stall, flush;
    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .wb    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference stage contents and retire count
    logic        m_valid, m_rw;
    logic [1:0]  m_lt, m_o;
    logic [4:0]  m_rd;
    logic [31:0] m_ex, m_mem, m_ret;

    typedef struct {
        logic        rw;
        logic [1:0]  lt;
        logic [1:0]  o;
        logic [4:0]  rd;
        logic [31:0] ex;
        logic [31:0] mem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [3:0]  en;
        logic [31:0] data;
        logic [3:0]  rs_sel;
        logic [3:0]  rt_sel;
    } vec_t;

    vec_t vec[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte j counts from the MSB; lwl fills bytes 0..3-o from m[o..3],
    // lwr fills bytes 3-o..3 from m[0..o].
    task automatic model_out(output logic [3:0] en, output logic [31:0] data);
        logic [7:0] m [4];
        en   = 4'b0000;
        data = 32'h0;
        for (int j = 0; j < 4; j++) m[j] = m_mem[31-8*j -: 8];
        case (m_lt)
            2'd0: begin data = m_ex;  en = 4'b1111; end
            2'd1: begin data = m_mem; en = 4'b1111; end
            2'd2: for (int j = 0; j < 4; j++)
                      if (j + int'(m_o) <= 3) begin
                          data[31-8*j -: 8] = m[j + int'(m_o)];
                          en[3-j] = 1'b1;
                      end
            default: begin
`ifdef WB_LWR_EN
                for (int j = 0; j < 4; j++)
                    if (j >= 3 - int'(m_o)) begin
                        data[31-8*j -: 8] = m[j - (3 - int'(m_o))];
                        en[3-j] = 1'b1;
                    end
`endif
            end
        endcase
        if (!(m_valid && m_rw && m_rd != 5'd0)) en = 4'b0000;
    endtask

    task automatic model_clock();
        if (rst) begin
            m_valid = 0; m_rw = 0; m_lt = 0; m_o = 0; m_rd = 0;
            m_ex = 0; m_mem = 0; m_ret = 0;
        end else begin
            if (!flush && !stall && bus.mw_valid) m_ret = m_ret + 1;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = bus.mw_valid;   m_rw  = bus.mw_reg_write;
                m_lt    = bus.mw_ld_type; m_o   = bus.mw_addr_lo;
                m_rd    = bus.mw_rd;      m_ex  = bus.mw_ex_result;
                m_mem   = bus.mw_mem_data;
            end
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  en;
        logic [31:0] data;
        model_out(en, data);
        check({tag, ".en"}, 32'(bus.rd_byte_w_en), 32'(en));
        check({tag, ".rs_sel"}, 32'(bus.rs_out_sel), (m_rd == bus.id_rs) ? 32'(en) : 32'h0);
        check({tag, ".rt_sel"}, 32'(bus.rt_out_sel), (m_rd == bus.id_rt) ? 32'(en) : 32'h0);
        if (en != 4'b0000) begin
            check({tag, ".addr"}, 32'(bus.rd_addr), 32'(m_rd));
            check({tag, ".data"}, bus.rd_data, data);
        end
        check({tag, ".retired"}, bus.retired, m_ret);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] lt, input logic [1:0] o,
                         input logic [4:0] rd, input logic [31:0] ex, input logic [31:0] mem,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.mw_valid = v;  bus.mw_reg_write = rw; bus.mw_ld_type = lt; bus.mw_addr_lo = o;
        bus.mw_rd = rd;    bus.mw_ex_result = ex; bus.mw_mem_data = mem;
        bus.id_rs = rs;    bus.id_rt = rt;
    endtask

    initial begin
        logic [31:0] ret_hold;

        vec[0]  = '{1'b1, 2'd0, 2'd0, 5'd5, 32'h12345678, 32'h0,        5'd5, 5'd6, 4'b1111, 32'h12345678, 4'b1111, 4'b0000};
        vec[1]  = '{1'b1, 2'd2, 2'd2, 5'd7, 32'h0,        32'hAABBCCDD, 5'd7, 5'd7, 4'b1100, 32'hCCDD0000, 4'b1100, 4'b1100};
        vec[2]  = '{1'b1, 2'd2, 2'd0, 5'd7, 32'h0,        32'hAABBCCDD, 5'd1, 5'd7, 4'b1111, 32'hAABBCCDD, 4'b0000, 4'b1111};
        vec[3]  = '{1'b1, 2'd2, 2'd1, 5'd8, 32'h0,        32'hAABBCCDD, 5'd8, 5'd2, 4'b1110, 32'hBBCCDD00, 4'b1110, 4'b0000};
        vec[4]  = '{1'b1, 2'd2, 2'd3, 5'd8, 32'h0,        32'hAABBCCDD, 5'd3, 5'd8, 4'b1000, 32'hDD000000, 4'b0000, 4'b1000};
        vec[5]  = '{1'b1, 2'd1, 2'd3, 5'd9, 32'h0,        32'h11223344, 5'd9, 5'd9, 4'b1111, 32'h11223344, 4'b1111, 4'b1111};
        vec[6]  = '{1'b1, 2'd0, 2'd0, 5'd0, 32'hDEADBEEF, 32'h0,        5'd0, 5'd0, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        vec[7]  = '{1'b0, 2'd0, 2'd0, 5'd9, 32'hDEADBEEF, 32'h0,        5'd9, 5'd9, 4'b0000, 32'h0,        4'b0000, 4'b0000};
`ifdef WB_LWR_EN
        vec[8]  = '{1'b1, 2'd3, 2'd1, 5'd4, 32'h0,        32'hAABBCCDD, 5'd4, 5'd0, 4'b0011, 32'h0000AABB, 4'b0011, 4'b0000};
        vec[9]  = '{1'b1, 2'd3, 2'd3, 5'd4, 32'h0,        32'hAABBCCDD, 5'd0, 5'd4, 4'b1111, 32'hAABBCCDD, 4'b0000, 4'b1111};
        vec[10] = '{1'b1, 2'd3, 2'd0, 5'd4, 32'h0,        32'hAABBCCDD, 5'd4, 5'd4, 4'b0001, 32'h000000AA, 4'b0001, 4'b0001};
`else
        vec[8]  = '{1'b1, 2'd3, 2'd1, 5'd4, 32'h0,        32'hAABBCCDD, 5'd4, 5'd0, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        vec[9]  = '{1'b1, 2'd3, 2'd3, 5'd4, 32'h0,        32'hAABBCCDD, 5'd0, 5'd4, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        vec[10] = '{1'b1, 2'd3, 2'd0, 5'd4, 32'h0,        32'hAABBCCDD, 5'd4, 5'd4, 4'b0000, 32'h0,        4'b0000, 4'b0000};
`endif
        vec[11] = '{1'b1, 2'd0, 2'd2, 5'd31, 32'hFFFF0001, 32'h0,       5'd31, 5'd30, 4'b1111, 32'hFFFF0001, 4'b1111, 4'b0000};

        // Reset held two cycles with a valid instruction presented
        rst = 1; stall = 0; flush = 0;
        drive(1, 1, 2'd0, 2'd0, 5'd5, 32'h12345678, 32'h0, 5'd0, 5'd0);
        step(); step();
        check("rst.en", 32'(bus.rd_byte_w_en), 32'h0);
        check("rst.addr", 32'(bus.rd_addr), 32'h0);
        check("rst.data", bus.rd_data, 32'h0);
        check("rst.rs_sel", 32'(bus.rs_out_sel), 32'h0);
        check("rst.rt_sel", 32'(bus.rt_out_sel), 32'h0);
        check("rst.retired", bus.retired, 32'h0);
        rst = 0;

        foreach (vec[i]) begin
            drive(1, vec[i].rw, vec[i].lt, vec[i].o, vec[i].rd, vec[i].ex, vec[i].mem,
                  vec[i].rs, vec[i].rt);
            step();
            check($sformatf("vec%0d.en", i), 32'(bus.rd_byte_w_en), 32'(vec[i].en));
            check($sformatf("vec%0d.rs_sel", i), 32'(bus.rs_out_sel), 32'(vec[i].rs_sel));
            check($sformatf("vec%0d.rt_sel", i), 32'(bus.rt_out_sel), 32'(vec[i].rt_sel));
            if (vec[i].en != 4'b0000) begin
                check($sformatf("vec%0d.addr", i), 32'(bus.rd_addr), 32'(vec[i].rd));
                check($sformatf("vec%0d.data", i), bus.rd_data, vec[i].data);
            end
            check($sformatf("vec%0d.retired", i), bus.retired, 32'(i + 1));
        end

        // Stall three cycles with new inputs waiting, then flush together with stall
        drive(1, 1, 2'd0, 2'd0, 5'd3, 32'hCAFEF00D, 32'h0, 5'd3, 5'd3);
        step();
        ret_hold = bus.retired;
        check("pre_stall.retired", ret_hold, 32'd13);
        stall = 1;
        drive(1, 1, 2'd1, 2'd0, 5'd6, 32'h0, 32'h55555555, 5'd3, 5'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d.en", k), 32'(bus.rd_byte_w_en), 32'hF);
            check($sformatf("stall%0d.data", k), bus.rd_data, 32'hCAFEF00D);
            check($sformatf("stall%0d.addr", k), 32'(bus.rd_addr), 32'd3);
            check($sformatf("stall%0d.rs_sel", k), 32'(bus.rs_out_sel), 32'hF);
            check($sformatf("stall%0d.retired", k), bus.retired, ret_hold);
        end
        flush = 1;
        step();
        check("flush.en", 32'(bus.rd_byte_w_en), 32'h0);
        check("flush.rs_sel", 32'(bus.rs_out_sel), 32'h0);
        check("flush.retired", bus.retired, ret_hold);
        flush = 0; stall = 0;

        // Reset asserted during a stall drops the pending write
        drive(1, 1, 2'd0, 2'd0, 5'd10, 32'h0BADF00D, 32'h0, 5'd10, 5'd10);
        step();
        check("pre_rst.en", 32'(bus.rd_byte_w_en), 32'hF);
        stall = 1; rst = 1;
        step();
        check("rst_stall.en", 32'(bus.rd_byte_w_en), 32'h0);
        check("rst_stall.retired", bus.retired, 32'h0);
        rst = 0; stall = 0;

        // Randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
